// File: rtl/arm_mc_controller_pkg.sv
// arm_mc_pkg: shared types, decode constants and condition logic for the multicycle controller
package arm_mc_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
    S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
  } state_t;
  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
  } ctl_t;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_TEQ = 4'b1001;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_CMN = 4'b1011;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  // Odd condition codes are the complement of the even one below them; 1111 never executes
  function automatic logic condcheck(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, r;
    {n, z, c, v} = f;
    case (cond[3:1])
      3'd0:    r = z;
      3'd1:    r = c;
      3'd2:    r = n;
      3'd3:    r = v;
      3'd4:    r = c & ~z;
      3'd5:    r = n == v;
      3'd6:    r = ~z & (n == v);
      default: r = 1'b1;
    endcase
    return (cond == 4'hF) ? 1'b0 : r ^ cond[0];
  endfunction
  function automatic ctl_t ctl_of(input state_t s, input logic ce, input logic rd15);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.pc_write = 1'b1; c.ir_write = 1'b1; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10; end
      S_DECODE: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10; end
      S_MEMADR: c.alu_src_b = 2'b01;
      S_MEMRD:  c.adr_src = 1'b1;
      S_MEMWB:  begin c.result_src = 2'b01; c.reg_write = ce; end
      S_MEMWR:  begin c.adr_src = 1'b1; c.mem_write = ce; end
      S_EXECI:  c.alu_src_b = 2'b01;
      S_ALUWB:  begin c.reg_write = ce; c.pc_write = ce & rd15; end
      S_BRANCH: begin c.alu_src_b = 2'b01; c.result_src = 2'b10; c.pc_write = ce; end
      default:  c = '0;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/arm_mc_controller_if.sv
// arm_mc_controller_if: IR/flag inputs and datapath control outputs of the multicycle controller
interface arm_mc_controller_if #(parameter int ALUCTRL_W = 3);
  logic [19:0]          instr;
  logic [3:0]           alu_flags;
  logic                 pc_write;
  logic                 adr_src;
  logic                 mem_write;
  logic                 ir_write;
  logic [1:0]           result_src;
  logic                 alu_src_a;
  logic [1:0]           alu_src_b;
  logic [1:0]           imm_src;
  logic [1:0]           reg_src;
  logic                 reg_write;
  logic [ALUCTRL_W-1:0] alu_control;
  logic [3:0]           state_o;
  modport master (
    input  instr, alu_flags,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, reg_src, reg_write, alu_control, state_o
  );
  modport slave (
    output instr, alu_flags,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, reg_src, reg_write, alu_control, state_o
  );
endinterface

// File: rtl/arm_mc_controller_aludec.sv
// arm_mc_aludec: data-processing cmd to ALU op, writeback suppression and flag-write class
module arm_mc_aludec
  import arm_mc_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter bit EXT_OPS   = 1'b1
) (
  input  logic [3:0]           i_cmd,
  input  logic                 i_s,
  output logic [ALUCTRL_W-1:0] o_alu_control,
  output logic                 o_no_write,
  output logic [1:0]           o_flag_w
);
  logic [2:0] w_op;
  logic       w_cmp;
  logic       w_arith;
  logic       w_valid;
  logic       w_nz;
  always_comb begin
    w_op    = ALU_ADD;
    w_cmp   = 1'b0;
    w_arith = 1'b0;
    w_valid = 1'b1;
    case (i_cmd)
      CMD_ADD: w_arith = 1'b1;
      CMD_SUB: begin w_op = ALU_SUB; w_arith = 1'b1; end
      CMD_AND: w_op = ALU_AND;
      CMD_ORR: w_op = ALU_ORR;
      CMD_CMP: begin w_op = ALU_SUB; w_arith = 1'b1; w_cmp = 1'b1; end
      CMD_TST: begin w_op = ALU_AND; w_cmp = 1'b1; end
      CMD_EOR: begin w_op = ALU_EOR; w_valid = EXT_OPS; end
      CMD_CMN: begin w_arith = 1'b1; w_cmp = 1'b1; w_valid = EXT_OPS; end
      CMD_TEQ: begin w_op = ALU_EOR; w_cmp = 1'b1; w_valid = EXT_OPS; end
      default: w_valid = 1'b0;
    endcase
  end
  // Unimplemented commands degrade to a flagless, writeless ADD
  assign o_alu_control = w_valid ? ALUCTRL_W'(w_op) : ALUCTRL_W'(ALU_ADD);
  assign o_no_write    = w_cmp | ~w_valid;
  assign w_nz          = w_valid & (i_s | w_cmp);
  assign o_flag_w      = {w_nz, w_nz & w_arith};
endmodule

// File: rtl/arm_mc_controller.sv
// arm_mc_controller: multicycle ARM control FSM with registered control outputs and flag register
module arm_mc_controller
  import arm_mc_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter bit EXT_OPS   = 1'b1
) (
  input logic clk,
  input logic reset,
  arm_mc_controller_if.master bus
);
  state_t               r_state;
  ctl_t                 r_ctl;
  logic [3:0]           r_flags;
  logic                 r_cond_ex;
  logic [ALUCTRL_W-1:0] r_alu_control;
  state_t               w_next;
  logic [1:0]           w_op;
  logic                 w_i;
  logic                 w_sl;
  logic                 w_rd15;
  logic                 w_cond_ex;
  logic                 w_ce;
  logic                 w_exec;
  logic                 w_exec_next;
  logic [ALUCTRL_W-1:0] w_alu_control;
  logic                 w_no_write;
  logic [1:0]           w_flag_w;
  logic                 w_unused;
  assign w_op        = bus.instr[15:14];
  assign w_i         = bus.instr[13];
  assign w_sl        = bus.instr[8];
  assign w_rd15      = &bus.instr[3:0];
  assign w_unused    = ^bus.instr[7:4];
  assign w_cond_ex   = condcheck(bus.instr[19:16], r_flags);
  assign w_exec      = (r_state == S_EXECR) || (r_state == S_EXECI);
  assign w_exec_next = (w_next == S_EXECR) || (w_next == S_EXECI);
  // Leaving DECODE the condition is still combinational; later states use the latched copy
  assign w_ce        = (r_state == S_DECODE) ? w_cond_ex : r_cond_ex;
  arm_mc_aludec #(.ALUCTRL_W(ALUCTRL_W), .EXT_OPS(EXT_OPS)) u_aludec (
    .i_cmd         (bus.instr[12:9]),
    .i_s           (w_sl),
    .o_alu_control (w_alu_control),
    .o_no_write    (w_no_write),
    .o_flag_w      (w_flag_w)
  );
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:          w_next = S_DECODE;
      S_DECODE:         w_next = (w_op == OP_MEM) ? S_MEMADR :
                                 (w_op == OP_BR)  ? S_BRANCH :
                                 (w_op == OP_DP)  ? (w_i ? S_EXECI : S_EXECR) : S_FETCH;
      S_MEMADR:         w_next = w_sl ? S_MEMRD : S_MEMWR;
      S_MEMRD:          w_next = S_MEMWB;
      S_EXECR, S_EXECI: w_next = w_no_write ? S_FETCH : S_ALUWB;
      default:          w_next = S_FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_FETCH;
      r_ctl         <= ctl_of(S_FETCH, 1'b0, 1'b0);
      r_alu_control <= ALUCTRL_W'(ALU_ADD);
      r_flags       <= '0;
      r_cond_ex     <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_ctl         <= ctl_of(w_next, w_ce, w_rd15);
      r_alu_control <= w_exec_next ? w_alu_control : ALUCTRL_W'(ALU_ADD);
      if (r_state == S_DECODE) r_cond_ex <= w_cond_ex;
      if (w_exec && r_cond_ex && w_flag_w[1]) r_flags[3:2] <= bus.alu_flags[3:2];
      if (w_exec && r_cond_ex && w_flag_w[0]) r_flags[1:0] <= bus.alu_flags[1:0];
    end
  end
  assign bus.pc_write    = r_ctl.pc_write;
  assign bus.adr_src     = r_ctl.adr_src;
  assign bus.mem_write   = r_ctl.mem_write;
  assign bus.ir_write    = r_ctl.ir_write;
  assign bus.result_src  = r_ctl.result_src;
  assign bus.alu_src_a   = r_ctl.alu_src_a;
  assign bus.alu_src_b   = r_ctl.alu_src_b;
  assign bus.reg_write   = r_ctl.reg_write;
  assign bus.alu_control = r_alu_control;
  assign bus.state_o     = r_state;
  assign bus.imm_src     = (w_op == OP_MEM) ? 2'b01 : (w_op == OP_BR) ? 2'b10 : 2'b00;
  assign bus.reg_src     = (w_op == OP_BR) ? 2'b01 : (w_op == OP_MEM && !w_sl) ? 2'b10 : 2'b00;
endmodule

// File: tb/tb_arm_mc_controller.sv
// tb_arm_mc_controller: directed instruction sequences against both decoder configurations
module tb_arm_mc_controller;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  arm_mc_controller_if #(.ALUCTRL_W(3)) bm ();
  arm_mc_controller_if #(.ALUCTRL_W(2)) be ();
  arm_mc_controller #(.ALUCTRL_W(3), .EXT_OPS(1'b1)) dut  (.clk(clk), .reset(reset), .bus(bm));
  arm_mc_controller #(.ALUCTRL_W(2), .EXT_OPS(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(be));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic sm(input string tag, input logic [3:0] s, input logic [4:0] en, input logic [1:0] res);
    chk(tag, {5'b0, bm.state_o, bm.pc_write, bm.mem_write, bm.reg_write, bm.ir_write, bm.adr_src, bm.result_src},
             {5'b0, s, en, res});
  endtask
  task automatic se(input string tag, input logic [3:0] s, input logic [4:0] en, input logic [1:0] res);
    chk(tag, {5'b0, be.state_o, be.pc_write, be.mem_write, be.reg_write, be.ir_write, be.adr_src, be.result_src},
             {5'b0, s, en, res});
  endtask
  initial begin
    reset = 1'b1;
    bm.instr = '0; bm.alu_flags = '0; be.instr = '0; be.alu_flags = '0;
    repeat (2) @(negedge clk);
    sm("rst_fetch", 4'd0, 5'b10010, 2'b10);
    chk("rst_flags", {12'b0, dut.r_flags}, 16'h0000);
    reset = 1'b0;
    bm.instr = 20'hE2800;
    @(negedge clk); sm("addi_dec", 4'd1, 5'b00000, 2'b10);
    chk("addi_dec_srcs", {13'b0, bm.alu_src_a, bm.alu_src_b}, 16'h0006);
    @(negedge clk); sm("addi_exec", 4'd7, 5'b00000, 2'b00);
    chk("addi_alu", {8'b0, bm.alu_src_a, bm.alu_src_b, bm.imm_src, bm.alu_control}, {8'b0, 1'b0, 2'b01, 2'b00, 3'b000});
    @(negedge clk); sm("addi_wb", 4'd8, 5'b00100, 2'b00);
    @(negedge clk); sm("addi_fetch", 4'd0, 5'b10010, 2'b10);
    bm.instr = 20'hE5901;
    @(negedge clk); sm("ldr_dec", 4'd1, 5'b00000, 2'b10);
    chk("ldr_imm_reg", {12'b0, bm.imm_src, bm.reg_src}, 16'h0004);
    @(negedge clk); sm("ldr_adr", 4'd2, 5'b00000, 2'b00);
    chk("ldr_adr_srcs", {13'b0, bm.alu_src_a, bm.alu_src_b}, 16'h0001);
    @(negedge clk); sm("ldr_rd", 4'd3, 5'b00001, 2'b00);
    @(negedge clk); sm("ldr_wb", 4'd4, 5'b00100, 2'b01);
    @(negedge clk); sm("ldr_fetch", 4'd0, 5'b10010, 2'b10);
    bm.instr = 20'hE5801;
    @(negedge clk); sm("str_dec", 4'd1, 5'b00000, 2'b10);
    chk("str_imm_reg", {12'b0, bm.imm_src, bm.reg_src}, 16'h0006);
    @(negedge clk); sm("str_adr", 4'd2, 5'b00000, 2'b00);
    @(negedge clk); sm("str_wr", 4'd5, 5'b01001, 2'b00);
    @(negedge clk); sm("str_fetch", 4'd0, 5'b10010, 2'b10);
    bm.instr = 20'hE3500; bm.alu_flags = 4'b0100;
    @(negedge clk); sm("cmp_dec", 4'd1, 5'b00000, 2'b10);
    @(negedge clk); sm("cmp_exec", 4'd7, 5'b00000, 2'b00);
    chk("cmp_alu", {13'b0, bm.alu_control}, 16'h0001);
    @(negedge clk); sm("cmp_fetch", 4'd0, 5'b10010, 2'b10);
    chk("cmp_flags", {12'b0, dut.r_flags}, 16'h0004);
    bm.instr = 20'h0A000; bm.alu_flags = 4'b0000;
    @(negedge clk); sm("beq_dec", 4'd1, 5'b00000, 2'b10);
    chk("beq_imm_reg", {12'b0, bm.imm_src, bm.reg_src}, 16'h0009);
    @(negedge clk); sm("beq_br", 4'd9, 5'b10000, 2'b10);
    chk("beq_srcs", {13'b0, bm.alu_src_a, bm.alu_src_b}, 16'h0001);
    @(negedge clk); sm("beq_fetch", 4'd0, 5'b10010, 2'b10);
    bm.instr = 20'h1A000;
    @(negedge clk); sm("bne_dec", 4'd1, 5'b00000, 2'b10);
    @(negedge clk); sm("bne_br", 4'd9, 5'b00000, 2'b10);
    @(negedge clk); sm("bne_fetch", 4'd0, 5'b10010, 2'b10);
    bm.instr = 20'hE3100; bm.alu_flags = 4'b1011;
    @(negedge clk); sm("tst_dec", 4'd1, 5'b00000, 2'b10);
    @(negedge clk); sm("tst_exec", 4'd7, 5'b00000, 2'b00);
    chk("tst_alu", {13'b0, bm.alu_control}, 16'h0002);
    @(negedge clk); sm("tst_fetch", 4'd0, 5'b10010, 2'b10);
    chk("tst_flags", {12'b0, dut.r_flags}, 16'h0008);
    bm.instr = 20'h4A000; bm.alu_flags = 4'b0000;
    @(negedge clk); sm("bmi_dec", 4'd1, 5'b00000, 2'b10);
    @(negedge clk); sm("bmi_br", 4'd9, 5'b10000, 2'b10);
    @(negedge clk); sm("bmi_fetch", 4'd0, 5'b10010, 2'b10);
    bm.instr = 20'h2A000;
    @(negedge clk); sm("bcs_dec", 4'd1, 5'b00000, 2'b10);
    @(negedge clk); sm("bcs_br", 4'd9, 5'b00000, 2'b10);
    @(negedge clk); sm("bcs_fetch", 4'd0, 5'b10010, 2'b10);
    bm.instr = 20'h02800;
    @(negedge clk); sm("addeq_dec", 4'd1, 5'b00000, 2'b10);
    @(negedge clk); sm("addeq_exec", 4'd7, 5'b00000, 2'b00);
    @(negedge clk); sm("addeq_wb", 4'd8, 5'b00000, 2'b00);
    @(negedge clk); sm("addeq_fetch", 4'd0, 5'b10010, 2'b10);
    bm.instr = 20'hE280F;
    @(negedge clk); sm("addpc_dec", 4'd1, 5'b00000, 2'b10);
    @(negedge clk); sm("addpc_exec", 4'd7, 5'b00000, 2'b00);
    @(negedge clk); sm("addpc_wb", 4'd8, 5'b10100, 2'b00);
    @(negedge clk); sm("addpc_fetch", 4'd0, 5'b10010, 2'b10);
    bm.instr = 20'hE5901;
    @(negedge clk); sm("rldr_dec", 4'd1, 5'b00000, 2'b10);
    @(negedge clk); sm("rldr_adr", 4'd2, 5'b00000, 2'b00);
    @(negedge clk); sm("rldr_rd", 4'd3, 5'b00001, 2'b00);
    reset = 1'b1;
    @(negedge clk); sm("rldr_abort", 4'd0, 5'b10010, 2'b10);
    chk("rldr_flags", {12'b0, dut.r_flags}, 16'h0000);
    reset = 1'b0;
    bm.instr = 20'hEC000;
    be.instr = 20'hE0300; be.alu_flags = 4'b1111;
    @(negedge clk); sm("ill_dec", 4'd1, 5'b00000, 2'b10);
    se("eor0_dec", 4'd1, 5'b00000, 2'b10);
    @(negedge clk); sm("ill_fetch", 4'd0, 5'b10010, 2'b10);
    se("eor0_exec", 4'd6, 5'b00000, 2'b00);
    chk("eor0_alu", {14'b0, be.alu_control}, 16'h0000);
    @(negedge clk); se("eor0_fetch", 4'd0, 5'b10010, 2'b10);
    chk("eor0_flags", {12'b0, dut0.r_flags}, 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/arm_mc_controller.md
Name: arm_mc_controller

Overview:
Parametrised multicycle control unit for the ARMv4-subset core. It replaces the single-cycle decoder/condlogic pair with a state machine that sequences each instruction over 3-5 cycles through a shared memory port and a single ALU.
- Generalised features: native CMP/TST (no register writeback), optional extended data-processing ops, and a parametrised ALU control width.
- Placement: sits beside the multicycle datapath (IR, A/B/ALUOut/Data registers) inside the arm core.

Parameters:
ALUCTRL_W, 3, width of alu_control; minimum 2; must be 3 when EXT_OPS=1
EXT_OPS, 1, 1 enables EOR/CMN/TEQ decode; 0 restricts to ADD/SUB/AND/ORR/CMP/TST

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high
instr  in  20  instr[31:12] from the instruction register
alu_flags  in  4  {N,Z,C,V} from the ALU
pc_write  out  1  PC register enable
adr_src  out  1  0 = PC, 1 = ALUOut drives the memory address
mem_write  out  1  data memory write enable
ir_write  out  1  IR enable
result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
alu_src_a  out  1  0 = A register, 1 = PC
alu_src_b  out  2  00 = WriteData, 01 = ExtImm, 10 = constant 4
imm_src  out  2  extend select (00 imm8, 01 imm12, 10 branch)
reg_src  out  2  register-address mux selects, as in the single-cycle core
reg_write  out  1  register file write enable
alu_control  out  ALUCTRL_W  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR
state_o  out  4  current state, for debug and bench observation

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- Reset:
  - On the clk edge with reset=1, state goes to FETCH; flags and cond_ex_q go to 0.
  - Reset has priority over every transition, including mid-instruction.
  - While in FETCH after reset, all write enables are combinationally valid; no stale mem_write or reg_write leaks from the aborted instruction.
- FETCH:
  - Outputs: adr_src=0, ir_write=1, alu_src_a=1, alu_src_b=10, ADD, result_src=10, pc_write=1.
  - Next state: DECODE.
- DECODE:
  - Outputs: alu_src_a=1, alu_src_b=10, ADD, result_src=10 (R15 = PC+8). No enables.
  - cond_ex_q <= condcheck(instr[31:28], flags).
  - Next state by op: op=01 -> MEMADR; op=10 -> BRANCH; op=00 -> EXECI if funct[5], else EXECR.
  - op=11 is illegal -> FETCH; no side effects.
- MEMADR: alu_src_a=0, alu_src_b=01, ADD. Next: MEMRD if L=1, else MEMWR.
- MEMRD: adr_src=1, result_src=00. Next: MEMWB.
- MEMWB: result_src=01, reg_write=cond_ex_q. Next: FETCH.
- MEMWR: adr_src=1, mem_write=cond_ex_q. Next: FETCH.
- EXECR / EXECI:
  - Outputs: alu_src_a=0, alu_src_b=00 (EXECR) or 01 (EXECI).
  - alu_control comes from the ALU decoder.
  - Flags capture at the end of this cycle when S=1 and cond_ex_q=1: NZ always; CV only for ADD/SUB/CMP/CMN.
  - Next state: FETCH if no_write, else ALUWB.
- ALUWB: result_src=00, reg_write=cond_ex_q. If rd=15 and cond_ex_q, pc_write=1. Next: FETCH.
- BRANCH: alu_src_a=0, alu_src_b=01, imm_src=10, result_src=10, pc_write=cond_ex_q. Next: FETCH.
- ALU decoder (cmd = funct[4:1]):
  - 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR.
  - 1010 CMP -> SUB with no_write=1; 1000 TST -> AND with no_write=1.
  - EXT_OPS=1 adds: 0001 EOR, 1011 CMN -> ADD with no_write=1, 1001 TEQ -> EOR with no_write=1.
  - An unimplemented cmd behaves as ADD, no_write=1, no flag write (instruction becomes a NOP).
  - CMP/TST/CMN/TEQ always write flags, regardless of the S bit.
- imm_src and reg_src depend on op only (decoded combinationally from the IR):
  - Data-processing: 00 / 00.
  - LDR: 01 / 00.
  - STR: 01 / 10.
  - B: 10 / 01.
- Latency (cycles): DP 4, CMP-class 3, LDR 5, STR 4, B 3, illegal 2.

Decomposition:
- Package arm_mc_pkg: state enum, alu_control constants, op and cmd localparams, and the condcheck function.
- One sub-module, arm_mc_aludec (cmd -> alu_control, no_write, flag-write class), instantiated once.
- The FSM, flag register and cond_ex_q live in the top module.

Test Plan:
- Reset pulse mid-LDR (in MEMRD) -> next state FETCH, reg_write=0, flags=0000.
- instr=0xE2800 (ADDI R0,R0,#5) -> FETCH, DECODE, EXECI, ALUWB; reg_write=1 only in ALUWB; alu_control=000; 4 cycles.
- LDR 0xE5901 -> 5 states, adr_src=1 in MEMRD, result_src=01 with reg_write=1 in MEMWB. STR 0xE5801 -> mem_write=1 only in MEMWR.
- CMP 0xE3500 with alu_flags=0100 -> EXECI goes to FETCH, no ALUWB, reg_write never 1, flags=0100. Then BEQ 0x0A000 -> pc_write=1 in BRANCH; BNE 0x1A000 -> pc_write=0.
- TST 0xE3100 with alu_flags=1011 -> flags N=1, Z=0; C and V keep their previous values 00.
- EXT_OPS=0 with EOR cmd 0001 -> NOP: 3 cycles, no reg_write, flags unchanged. Illegal op=11 -> FETCH after DECODE, no enables asserted.
